// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use bubbles, branch redirects, dmem freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned XADDR    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dec_valid,
  input  logic             i_dec_uses_rs1,
  input  logic             i_dec_uses_rs2,
  input  logic [XADDR-1:0] i_dec_rs1_addr,
  input  logic [XADDR-1:0] i_dec_rs2_addr,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_load,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic             i_ex_branch_taken,
  input  logic [XLEN-1:0]  i_ex_target,
  input  logic             i_imem_ack,
  input  logic             i_dmem_busy,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic [1:0]       o_state
`ifdef HAZARD_PERF_EN
 ,output logic [CNT_W-1:0] o_cnt_lu,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic [CNT_W-1:0] o_cnt_freeze
`endif
);

  localparam int unsigned CW       = 3;
  localparam bit          LU_MULTI = (LOAD_LAT > 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    FETCH_WAIT = 2'd2,
    ILLEGAL    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu_c;
  logic          redir_c;

  assign lu_c = i_ex_valid & i_ex_is_load & (i_ex_rd_addr != '0) & i_dec_valid &
                ((i_dec_uses_rs1 & (i_dec_rs1_addr == i_ex_rd_addr)) |
                 (i_dec_uses_rs2 & (i_dec_rs2_addr == i_ex_rd_addr)));
  assign redir_c = i_ex_valid & i_ex_branch_taken;

  // State and remaining-bubble counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: freeze holds everything, redirect overrides any stall in progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ILLEGAL) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (i_dmem_busy) begin
      state_d = state_q;
    end else if (redir_c) begin
      cnt_d   = '0;
      state_d = i_imem_ack ? RUN : FETCH_WAIT;
    end else begin
      case (state_q)
        RUN: begin
          if (lu_c && LU_MULTI) begin
            cnt_d   = CW'(LOAD_LAT - 1);
            state_d = LU_STALL;
          end
        end
        LU_STALL: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        FETCH_WAIT: begin
          if (i_imem_ack) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Pipeline controls
  always_comb begin
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_id    = 1'b0;
    o_flush_ex    = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    if (!i_rst && (state_q != ILLEGAL)) begin
      if (i_dmem_busy) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_stall_ex = 1'b1;
      end else if (redir_c) begin
        o_redirect    = 1'b1;
        o_redirect_pc = i_ex_target;
        o_flush_id    = 1'b1;
        o_flush_ex    = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (lu_c) begin
              o_stall_if  = 1'b1;
              o_stall_id  = 1'b1;
              o_bubble_ex = 1'b1;
            end
          end
          LU_STALL: begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_bubble_ex = 1'b1;
          end
          FETCH_WAIT: begin
            // The acked fetch is accepted, so hold/flush only while still waiting
            if (!i_imem_ack) begin
              o_stall_id = 1'b1;
              o_flush_id = 1'b1;
            end
          end
          default: o_stall_if = 1'b0;
        endcase
      end
    end
  end

  assign o_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_lu_q, cnt_flush_q, cnt_freeze_q;

  // Event counters; stall_ex is only raised by a freeze
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_lu_q     <= '0;
      cnt_flush_q  <= '0;
      cnt_freeze_q <= '0;
    end else begin
      if (o_bubble_ex) cnt_lu_q     <= cnt_lu_q + CNT_W'(1);
      if (o_redirect)  cnt_flush_q  <= cnt_flush_q + CNT_W'(1);
      if (o_stall_ex)  cnt_freeze_q <= cnt_freeze_q + CNT_W'(1);
    end
  end

  assign o_cnt_lu     = cnt_lu_q;
  assign o_cnt_flush  = cnt_flush_q;
  assign o_cnt_freeze = cnt_freeze_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and are
// compared each cycle against a bubble/fetch-wait reference model.
module tb_hazard_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned XADDR = 5;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned OW    = XLEN + 9;

  typedef struct {
    bit             dv, u1, u2;
    bit [XADDR-1:0] rs1, rs2;
    bit             ev, ld;
    bit [XADDR-1:0] rd;
    bit             tk;
    bit [XLEN-1:0]  tgt;
    bit             ack, busy;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, uses_rs1, uses_rs2, ex_valid, ex_is_load, ex_taken, imem_ack, dmem_busy;
  logic [XADDR-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0]  ex_target;

  logic             stall_if[2], stall_id[2], stall_ex[2], bubble_ex[2];
  logic             flush_id[2], flush_ex[2], redirect[2];
  logic [XLEN-1:0]  redirect_pc[2];
  logic [1:0]       state[2];
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_lu[2], cnt_flush[2], cnt_freeze[2];
  int unsigned      m_lu[2], m_flush[2], m_freeze[2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int bl[2];   // bubbles still owed after the current cycle
  bit fw[2];   // waiting on the redirected fetch

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(XLEN), .XADDR(XADDR), .LOAD_LAT(1), .CNT_W(CNT_W)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst),
    .i_dec_valid(dec_valid), .i_dec_uses_rs1(uses_rs1), .i_dec_uses_rs2(uses_rs2),
    .i_dec_rs1_addr(rs1_addr), .i_dec_rs2_addr(rs2_addr),
    .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd_addr(rd_addr),
    .i_ex_branch_taken(ex_taken), .i_ex_target(ex_target),
    .i_imem_ack(imem_ack), .i_dmem_busy(dmem_busy),
    .o_stall_if(stall_if[0]), .o_stall_id(stall_id[0]), .o_stall_ex(stall_ex[0]),
    .o_bubble_ex(bubble_ex[0]), .o_flush_id(flush_id[0]), .o_flush_ex(flush_ex[0]),
    .o_redirect(redirect[0]), .o_redirect_pc(redirect_pc[0]), .o_state(state[0])
`ifdef HAZARD_PERF_EN
   ,.o_cnt_lu(cnt_lu[0]), .o_cnt_flush(cnt_flush[0]), .o_cnt_freeze(cnt_freeze[0])
`endif
  );

  hazard_ctrl #(.XLEN(XLEN), .XADDR(XADDR), .LOAD_LAT(3), .CNT_W(CNT_W)) u_dut_l3 (
    .i_clk(clk), .i_rst(rst),
    .i_dec_valid(dec_valid), .i_dec_uses_rs1(uses_rs1), .i_dec_uses_rs2(uses_rs2),
    .i_dec_rs1_addr(rs1_addr), .i_dec_rs2_addr(rs2_addr),
    .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd_addr(rd_addr),
    .i_ex_branch_taken(ex_taken), .i_ex_target(ex_target),
    .i_imem_ack(imem_ack), .i_dmem_busy(dmem_busy),
    .o_stall_if(stall_if[1]), .o_stall_id(stall_id[1]), .o_stall_ex(stall_ex[1]),
    .o_bubble_ex(bubble_ex[1]), .o_flush_id(flush_id[1]), .o_flush_ex(flush_ex[1]),
    .o_redirect(redirect[1]), .o_redirect_pc(redirect_pc[1]), .o_state(state[1])
`ifdef HAZARD_PERF_EN
   ,.o_cnt_lu(cnt_lu[1]), .o_cnt_flush(cnt_flush[1]), .o_cnt_freeze(cnt_freeze[1])
`endif
  );

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic stim_t mk(bit dv, bit u1, bit u2, int rs1, int rs2, bit ev, bit ld,
                               int rd, bit tk, bit [XLEN-1:0] tgt, bit ack, bit busy);
    stim_t s;
    s.dv = dv; s.u1 = u1; s.u2 = u2;
    s.rs1 = XADDR'(rs1); s.rs2 = XADDR'(rs2);
    s.ev = ev; s.ld = ld; s.rd = XADDR'(rd);
    s.tk = tk; s.tgt = tgt; s.ack = ack; s.busy = busy;
    return s;
  endfunction

  function automatic stim_t idle(bit ack);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, ack, 0);
  endfunction

  task automatic apply(input stim_t s);
    dec_valid = s.dv; uses_rs1 = s.u1; uses_rs2 = s.u2;
    rs1_addr = s.rs1; rs2_addr = s.rs2;
    ex_valid = s.ev; ex_is_load = s.ld; rd_addr = s.rd;
    ex_taken = s.tk; ex_target = s.tgt; imem_ack = s.ack; dmem_busy = s.busy;
  endtask

  function automatic bit lu_now();
    return ex_valid && ex_is_load && (rd_addr != 0) && dec_valid &&
           ((uses_rs1 && rs1_addr == rd_addr) || (uses_rs2 && rs2_addr == rd_addr));
  endfunction

  // Expected controls this cycle, from the priority rules and the owed-bubble/fetch-wait view
  function automatic logic [OW-1:0] model_out(int k);
    logic sif, sid, sex, bub, fid, fex, red;
    logic [XLEN-1:0] pc;
    logic [1:0] st;
    {sif, sid, sex, bub, fid, fex, red} = '0;
    pc = '0;
    st = (bl[k] > 0) ? 2'd1 : (fw[k] ? 2'd2 : 2'd0);
    if (rst) st = 2'd0;
    else if (dmem_busy) {sif, sid, sex} = 3'b111;
    else if (ex_valid && ex_taken) begin
      red = 1'b1; pc = ex_target; fid = 1'b1; fex = 1'b1;
    end else if (bl[k] > 0) {sif, sid, bub} = 3'b111;
    else if (fw[k]) begin
      if (!imem_ack) {sid, fid} = 2'b11;
    end else if (lu_now()) {sif, sid, bub} = 3'b111;
    return {sif, sid, sex, bub, fid, fex, red, pc, st};
  endfunction

  function automatic logic [OW-1:0] dut_out(int k);
    return {stall_if[k], stall_id[k], stall_ex[k], bubble_ex[k], flush_id[k], flush_ex[k],
            redirect[k], redirect_pc[k], state[k]};
  endfunction

  task automatic model_advance();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        bl[k] = 0; fw[k] = 1'b0;
`ifdef HAZARD_PERF_EN
        m_lu[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
`endif
      end else if (dmem_busy) begin
`ifdef HAZARD_PERF_EN
        m_freeze[k]++;
`endif
      end else if (ex_valid && ex_taken) begin
`ifdef HAZARD_PERF_EN
        m_flush[k]++;
`endif
        bl[k] = 0; fw[k] = !imem_ack;
      end else if (bl[k] > 0) begin
`ifdef HAZARD_PERF_EN
        m_lu[k]++;
`endif
        bl[k]--;
      end else if (fw[k]) begin
        if (imem_ack) fw[k] = 1'b0;
      end else if (lu_now()) begin
`ifdef HAZARD_PERF_EN
        m_lu[k]++;
`endif
        bl[k] = lat_of(k) - 1;
      end
    end
  endtask

  task automatic test_reset();
    apply(idle(0));
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_out(k) !== '0) begin
        n_fail++;
        $display("FAIL reset_hold lat%0d: got %h want 0", lat_of(k), dut_out(k));
      end
    end
    @(posedge clk); model_advance(); @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_out(k) !== model_out(k)) begin
        n_fail++;
        $display("FAIL reset_release lat%0d: got %h want %h", lat_of(k), dut_out(k), model_out(k));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    stim_t v[$];
    logic [3:0] bub1, bub3;
    logic [7:0] st3;
    v.push_back(mk(1, 1, 0, 5, 0, 1, 1, 5, 0, '0, 0, 0));
    repeat (3) v.push_back(idle(0));
    v.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, '0, 0, 0));
    v.push_back(idle(0));
    v.push_back(mk(1, 0, 1, 3, 7, 1, 1, 7, 0, '0, 0, 0));
    repeat (3) v.push_back(idle(0));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_out(k) !== model_out(k)) begin
          n_fail++;
          $display("FAIL load_use step%0d lat%0d: got %h want %h", i, lat_of(k), dut_out(k), model_out(k));
        end
      end
      if (i >= 6) begin
        bub1[9-i] = bubble_ex[0];
        bub3[9-i] = bubble_ex[1];
        st3[2*(9-i) +: 2] = state[1];
      end
      @(posedge clk); model_advance(); @(negedge clk);
    end
    n_tests++;
    if (bub3 !== 4'b1110 || bub1 !== 4'b1000 || st3 !== 8'b00_01_01_00) begin
      n_fail++;
      $display("FAIL lu_rs2_trace: bub1=%b bub3=%b st3=%b want 1000 1110 00010100", bub1, bub3, st3);
    end
  endtask

  task automatic test_branch();
    stim_t v[$];
    logic [4:0] red1, fid1;
    v.push_back(mk(1, 1, 1, 1, 2, 1, 0, 3, 1, 32'h0000_0100, 0, 0));
    v.push_back(idle(0));
    v.push_back(idle(0));
    v.push_back(idle(1));
    v.push_back(idle(0));
    v.push_back(mk(1, 1, 0, 5, 0, 1, 1, 5, 0, '0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0200, 0, 0));
    v.push_back(idle(1));
    v.push_back(idle(0));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_out(k) !== model_out(k)) begin
          n_fail++;
          $display("FAIL branch step%0d lat%0d: got %h want %h", i, lat_of(k), dut_out(k), model_out(k));
        end
      end
      if (i < 5) begin
        red1[4-i] = redirect[0];
        fid1[4-i] = flush_id[0];
      end
      @(posedge clk); model_advance(); @(negedge clk);
    end
    n_tests++;
    if (red1 !== 5'b10000 || fid1 !== 5'b11100) begin
      n_fail++;
      $display("FAIL branch_trace: redirect=%b flush_id=%b want 10000 11100", red1, fid1);
    end
  endtask

  task automatic test_freeze();
    stim_t v[$];
    stim_t hot;
    logic [4:0] red3, sex3;
    hot = mk(1, 1, 0, 4, 0, 1, 1, 4, 1, 32'h0000_0300, 0, 1);
    repeat (4) v.push_back(hot);
    hot.busy = 1'b0;
    v.push_back(hot);
    v.push_back(idle(1));
    v.push_back(idle(0));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_out(k) !== model_out(k)) begin
          n_fail++;
          $display("FAIL freeze step%0d lat%0d: got %h want %h", i, lat_of(k), dut_out(k), model_out(k));
        end
      end
      if (i < 5) begin
        red3[4-i] = redirect[1];
        sex3[4-i] = stall_ex[1];
      end
      @(posedge clk); model_advance(); @(negedge clk);
    end
    n_tests++;
    if (red3 !== 5'b00001 || sex3 !== 5'b11110) begin
      n_fail++;
      $display("FAIL freeze_trace: redirect=%b stall_ex=%b want 00001 11110", red3, sex3);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0400, 0, 0));
    @(posedge clk); model_advance(); @(negedge clk);
    apply(idle(0));
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_out(k) !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_wait lat%0d: got %h want 0", lat_of(k), dut_out(k));
      end
    end
    @(posedge clk); model_advance(); @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (state[k] !== 2'd0 || dut_out(k) !== model_out(k)) begin
        n_fail++;
        $display("FAIL after_reset lat%0d: got %h want %h", lat_of(k), dut_out(k), model_out(k));
      end
`ifdef HAZARD_PERF_EN
      n_tests++;
      if (cnt_lu[k] !== '0 || cnt_flush[k] !== '0 || cnt_freeze[k] !== '0) begin
        n_fail++;
        $display("FAIL perf_reset lat%0d: got %0d/%0d/%0d want 0/0/0", lat_of(k),
                 cnt_lu[k], cnt_flush[k], cnt_freeze[k]);
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 600; i++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 9) == 0,
             $urandom, $urandom_range(0, 1), $urandom_range(0, 6) == 0);
      apply(s);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_out(k) !== model_out(k)) begin
          n_fail++;
          $display("FAIL random cyc%0d lat%0d: got %h want %h", i, lat_of(k), dut_out(k), model_out(k));
        end
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (cnt_lu[k] !== CNT_W'(m_lu[k]) || cnt_flush[k] !== CNT_W'(m_flush[k]) ||
            cnt_freeze[k] !== CNT_W'(m_freeze[k])) begin
          n_fail++;
          $display("FAIL perf cyc%0d lat%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, lat_of(k),
                   cnt_lu[k], cnt_flush[k], cnt_freeze[k], m_lu[k], m_flush[k], m_freeze[k]);
        end
`endif
      end
      @(posedge clk); model_advance(); @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bl[k] = 0; fw[k] = 1'b0;
`ifdef HAZARD_PERF_EN
      m_lu[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
`endif
    end
    apply(idle(0));
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I_Zicsr core.
- Sits beside decode and generates stall, bubble, flush and PC-redirect controls for the fetch, decode and execute stage registers.
- Detects load-use hazards against the decode-stage source addresses and handles taken-branch/jump redirects, including waiting on the instruction-memory handshake.
- Freezes the whole pipeline while data memory is busy.

Parameters:
- XLEN, 32, datapath/PC width.
- XADDR, 5, register address width.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard; legal range 1..7.
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_dec_valid  in  1  decode holds a valid instruction
- i_dec_uses_rs1  in  1  decode instruction reads rs1
- i_dec_uses_rs2  in  1  decode instruction reads rs2
- i_dec_rs1_addr  in  XADDR  decode rs1 address
- i_dec_rs2_addr  in  XADDR  decode rs2 address
- i_ex_valid  in  1  execute holds a valid instruction
- i_ex_is_load  in  1  execute instruction is a load
- i_ex_rd_addr  in  XADDR  execute destination address
- i_ex_branch_taken  in  1  execute resolved a taken branch/jump
- i_ex_target  in  XLEN  redirect target
- i_imem_ack  in  1  instruction memory returned a fetch
- i_dmem_busy  in  1  data memory access not complete
- o_stall_if  out  1  hold PC / IF-ID register
- o_stall_id  out  1  hold ID-EX inputs
- o_stall_ex  out  1  hold EX-MEM register
- o_bubble_ex  out  1  load a NOP into ID-EX
- o_flush_id  out  1  invalidate IF-ID register
- o_flush_ex  out  1  invalidate ID-EX register
- o_redirect  out  1  PC mux selects o_redirect_pc
- o_redirect_pc  out  XLEN  redirect target
- o_state  out  2  current FSM state (debug)

Behaviour:
- Clock is i_clk. Reset is i_rst, asynchronous and active-high.
- While i_rst is high:
  - State = RUN, bubble counter = 0.
  - All outputs = 0; o_redirect_pc = 0.
- Outputs are combinational from state, counter and inputs. State and counter are registered.
- Hazard condition lu = i_ex_valid & i_ex_is_load & (i_ex_rd_addr != 0) & i_dec_valid & ((i_dec_uses_rs1 & rs1==rd) | (i_dec_uses_rs2 & rs2==rd)). A rd of x0 never causes a hazard.
- Priority, highest first:
  - Freeze (i_dmem_busy): o_stall_if = o_stall_id = o_stall_ex = 1, all other outputs 0. State, counter and any pending condition hold. No branch or lu action is taken that cycle.
  - Redirect (i_ex_valid & i_ex_branch_taken, any state): o_redirect = 1, o_redirect_pc = i_ex_target, o_flush_id = 1, o_flush_ex = 1. Any in-progress LU_STALL is abandoned, counter cleared. Next state is FETCH_WAIT unless i_imem_ack is also high that cycle, in which case next state is RUN.
  - Load-use in RUN: o_stall_if = 1, o_stall_id = 1, o_bubble_ex = 1. If LOAD_LAT > 1, counter = LOAD_LAT-1 and next state = LU_STALL; otherwise stay in RUN.
- LU_STALL: drive the same three outputs. Counter decrements each unfrozen cycle; when the counter reaches 1, next state = RUN. Total bubbles per hazard = LOAD_LAT.
- FETCH_WAIT: o_stall_id = 1 and o_flush_id = 1 each cycle, so wrong-path or stale fetches never enter decode. On i_imem_ack, go to RUN; the acked instruction is accepted that cycle (flush deasserted that cycle).
- RUN with no event: all outputs 0.
- State encoding: RUN = 0, LU_STALL = 1, FETCH_WAIT = 2; 3 is illegal and recovers to RUN next cycle with all outputs 0.
- Reset mid-stall or mid-wait returns immediately to RUN with outputs 0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add three outputs, each CNT_W wide:
  - o_cnt_lu: increments once per lu stall cycle.
  - o_cnt_flush: increments once per redirect.
  - o_cnt_freeze: increments once per freeze cycle.
- Counters reset to 0 and wrap modulo 2^CNT_W.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Load-use, LOAD_LAT=1: EX load rd=5, decode uses rs1=5 -> exactly 1 cycle of stall_if/stall_id/bubble_ex, then RUN. Repeat with rd=0 -> no stall.
- LOAD_LAT=3, rs2 match (rd=7) -> 3 consecutive bubble cycles, o_state 0 -> 1 -> 1 -> 0.
- Taken branch, target 0x0000_0100, i_imem_ack low 2 cycles -> redirect and both flushes for 1 cycle; FETCH_WAIT keeps flush_id high for 2 cycles; RUN on the ack cycle.
- Branch during LU_STALL (LOAD_LAT=3, 2nd bubble cycle) -> redirect wins, counter cleared, FETCH_WAIT.
- i_dmem_busy high 4 cycles in the same cycle as lu and a taken branch -> 4 cycles of all-stall with no redirect; then redirect is taken on the first unfrozen cycle.
- Assert i_rst mid-FETCH_WAIT -> all outputs 0 immediately, RUN after release. With HAZARD_PERF_EN, counters read 0.
